// File: rtl/cond_pkg.sv
// Shared types for the execute-stage condition unit: instruction classes,
// condition encodings for both modes, and the NZCV flag layout.
package cond_pkg;

    typedef enum logic [1:0] {
        OP_DATA    = 2'b00,
        OP_MEM     = 2'b01,
        OP_BRANCH  = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        C3_AL = 3'b000,
        C3_EQ = 3'b001,
        C3_LT = 3'b010,
        C3_GT = 3'b011,
        C3_LE = 3'b100,
        C3_GE = 3'b101,
        C3_NE = 3'b110,
        C3_NV = 3'b111
    } cond3_t;

    typedef enum logic [3:0] {
        C4_EQ = 4'h0, C4_NE = 4'h1, C4_CS = 4'h2, C4_CC = 4'h3,
        C4_MI = 4'h4, C4_PL = 4'h5, C4_VS = 4'h6, C4_VC = 4'h7,
        C4_HI = 4'h8, C4_LS = 4'h9, C4_GE = 4'ha, C4_LT = 4'hb,
        C4_GT = 4'hc, C4_LE = 4'hd, C4_AL = 4'he, C4_NV = 4'hf
    } cond4_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition check: (op, cond, flags) -> cond_ex.
// COND_MODE 0 predicates branches only; COND_MODE 1 predicates every legal op.
module cond_eval
    import cond_pkg::*;
#(
    parameter int  COND_MODE = 0,
    localparam int COND_W    = (COND_MODE != 0) ? 4 : 3
) (
    input  logic [1:0]        op,
    input  logic [COND_W-1:0] cond,
    input  flags_t            flags,
    output logic              cond_ex
);

    if (COND_MODE == 0) begin : g_asip
        always_comb begin
            cond_ex = 1'b0;
            if (op == OP_ILLEGAL) begin
                cond_ex = 1'b0;
            end else if (op != OP_BRANCH) begin
                cond_ex = 1'b1;
            end else begin
                case (cond3_t'(cond[2:0]))
                    C3_AL:   cond_ex = 1'b1;
                    C3_EQ:   cond_ex = flags.z;
                    C3_LT:   cond_ex = flags.n ^ flags.v;
                    C3_GT:   cond_ex = ~flags.z & ~(flags.n ^ flags.v);
                    C3_LE:   cond_ex = flags.z | (flags.n ^ flags.v);
                    C3_GE:   cond_ex = ~(flags.n ^ flags.v);
                    C3_NE:   cond_ex = ~flags.z;
                    default: cond_ex = 1'b0;
                endcase
            end
        end
    end else begin : g_arm
        always_comb begin
            cond_ex = 1'b0;
            if (op != OP_ILLEGAL) begin
                case (cond4_t'(cond[3:0]))
                    C4_EQ:   cond_ex = flags.z;
                    C4_NE:   cond_ex = ~flags.z;
                    C4_CS:   cond_ex = flags.c;
                    C4_CC:   cond_ex = ~flags.c;
                    C4_MI:   cond_ex = flags.n;
                    C4_PL:   cond_ex = ~flags.n;
                    C4_VS:   cond_ex = flags.v;
                    C4_VC:   cond_ex = ~flags.v;
                    C4_HI:   cond_ex = flags.c & ~flags.z;
                    C4_LS:   cond_ex = ~flags.c | flags.z;
                    C4_GE:   cond_ex = ~(flags.n ^ flags.v);
                    C4_LT:   cond_ex = flags.n ^ flags.v;
                    C4_GT:   cond_ex = ~flags.z & ~(flags.n ^ flags.v);
                    C4_LE:   cond_ex = flags.z | (flags.n ^ flags.v);
                    C4_AL:   cond_ex = 1'b1;
                    default: cond_ex = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: per-context NZCV banks with partial writes,
// condition-gated write/branch enables and a saturating squash counter.
module cond_unit
    import cond_pkg::*;
#(
    parameter int  COND_MODE = 0,
    parameter int  NUM_CTX   = 1,
    parameter int  CNT_W     = 16,
    localparam int CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    localparam int COND_W    = (COND_MODE != 0) ? 4 : 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        op,
    input  logic [COND_W-1:0] cond,
    input  logic [CTX_W-1:0]  ctx,
    input  logic [3:0]        alu_flags,
    input  logic [1:0]        flag_write,
    input  logic              reg_write_in,
    input  logic              mem_write_in,
    input  logic              pc_src_in,
    output logic              cond_ex,
    output logic              reg_write,
    output logic              mem_write,
    output logic              pc_src,
    output logic [3:0]        flags,
    output logic [CNT_W-1:0]  skip_count
);

    flags_t            bank [NUM_CTX];
    flags_t            cur;
    logic [CTX_W-1:0]  ctx_sel;
    logic              advance;
    logic              flag_we;
    logic              skip_inc;

    // Out-of-range contexts alias bank 0.
    assign ctx_sel = ({1'b0, ctx} < (CTX_W + 1)'(NUM_CTX)) ? ctx : '0;

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (ctx_sel == CTX_W'(i)) begin
                cur = bank[i];
            end
        end
    end

    cond_eval #(.COND_MODE(COND_MODE)) u_eval (
        .op      (op),
        .cond    (cond),
        .flags   (cur),
        .cond_ex (cond_ex)
    );

    assign advance  = en & ~reset;
    assign flag_we  = advance & cond_ex;
    assign skip_inc = advance & ~cond_ex & (op != OP_ILLEGAL);

    assign reg_write = reg_write_in & cond_ex & advance;
    assign mem_write = mem_write_in & cond_ex & advance;
    assign pc_src    = pc_src_in    & cond_ex & advance;
    assign flags     = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                bank[i] <= '0;
            end
            skip_count <= '0;
        end else begin
            if (flag_we) begin
                for (int i = 0; i < NUM_CTX; i++) begin
                    if (ctx_sel == CTX_W'(i)) begin
                        if (flag_write[1]) begin
                            bank[i].n <= alu_flags[FLAG_N];
                            bank[i].z <= alu_flags[FLAG_Z];
                        end
                        if (flag_write[0]) begin
                            bank[i].c <= alu_flags[FLAG_C];
                            bank[i].v <= alu_flags[FLAG_V];
                        end
                    end
                end
            end
            // Saturate rather than wrap so a long squash burst never reads as few.
            if (skip_inc && (skip_count != '1)) begin
                skip_count <= skip_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: an ASIP-mode instance and a multi-context
// ARM-mode instance driven by directed and random stimulus against a reference model.
module tb_cond_unit;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [1:0] op;
        logic [3:0] cond;
        logic [1:0] ctx;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       rw;
        logic       mw;
        logic       ps;
    } stim_t;

    typedef struct packed {
        logic        ce;
        logic        rw;
        logic        mw;
        logic        ps;
        logic [3:0]  fl;
        logic [15:0] cnt;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ASIP mode, one bank, 2-bit counter
    logic       a_rst, a_en, a_rwi, a_mwi, a_psi;
    logic [1:0] a_op, a_fw;
    logic [2:0] a_cond;
    logic [0:0] a_ctx;
    logic [3:0] a_alu, a_flags;
    logic       a_ce, a_rw, a_mw, a_ps;
    logic [1:0] a_skip;

    // Instance B: ARM mode, three banks, 4-bit counter
    logic       b_rst, b_en, b_rwi, b_mwi, b_psi;
    logic [1:0] b_op, b_fw, b_ctx;
    logic [3:0] b_cond, b_alu, b_flags;
    logic       b_ce, b_rw, b_mw, b_ps;
    logic [3:0] b_skip;

    cond_unit #(.COND_MODE(0), .NUM_CTX(1), .CNT_W(2)) dut_a (
        .clk(clk), .reset(a_rst), .en(a_en), .op(a_op), .cond(a_cond), .ctx(a_ctx),
        .alu_flags(a_alu), .flag_write(a_fw), .reg_write_in(a_rwi), .mem_write_in(a_mwi),
        .pc_src_in(a_psi), .cond_ex(a_ce), .reg_write(a_rw), .mem_write(a_mw),
        .pc_src(a_ps), .flags(a_flags), .skip_count(a_skip)
    );

    cond_unit #(.COND_MODE(1), .NUM_CTX(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(b_rst), .en(b_en), .op(b_op), .cond(b_cond), .ctx(b_ctx),
        .alu_flags(b_alu), .flag_write(b_fw), .reg_write_in(b_rwi), .mem_write_in(b_mwi),
        .pc_src_in(b_psi), .cond_ex(b_ce), .reg_write(b_rw), .mem_write(b_mw),
        .pc_src(b_ps), .flags(b_flags), .skip_count(b_skip)
    );

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    resp_t qa[$];
    resp_t qb[$];

    // Reference state: flags per bank as {N,Z,C,V}, squash counts.
    logic [3:0]  mflags [2][4];
    int unsigned mcnt [2];

    // ASIP conditions expressed as their ARM equivalents.
    logic [3:0] m0map [8] = '{4'd14, 4'd0, 4'd11, 4'd12, 4'd13, 4'd10, 4'd1, 4'd15};

    function automatic logic arm_pass(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic stim_t mk(logic rst, logic en, logic [1:0] op, logic [3:0] cond,
                                 logic [1:0] ctx, logic [3:0] alu, logic [1:0] fw,
                                 logic rw, logic mw, logic ps);
        stim_t s;
        s = '{rst, en, op, cond, ctx, alu, fw, rw, mw, ps};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst  = ($urandom_range(0, 19) == 0);
        s.en   = ($urandom_range(0, 3) != 0);
        s.op   = 2'($urandom);
        s.cond = 4'($urandom);
        s.ctx  = 2'($urandom);
        s.alu  = 4'($urandom);
        s.fw   = 2'($urandom);
        s.rw   = 1'($urandom);
        s.mw   = 1'($urandom);
        s.ps   = 1'($urandom);
        return s;
    endfunction

    task automatic model(int d, stim_t s);
        int    nctx, idx, cmax;
        logic  pass, go;
        resp_t r;
        nctx = (d == 0) ? 1 : 3;
        cmax = (d == 0) ? 3 : 15;
        idx  = (d == 0) ? int'(s.ctx[0]) : int'(s.ctx);
        if (idx >= nctx) idx = 0;
        if (s.op == 2'b11) pass = 1'b0;
        else if (d == 0) pass = (s.op != 2'b10) ? 1'b1 : arm_pass(m0map[s.cond[2:0]], mflags[d][idx]);
        else pass = arm_pass(s.cond, mflags[d][idx]);
        go    = s.en && !s.rst;
        r.ce  = pass;
        r.rw  = s.rw && pass && go;
        r.mw  = s.mw && pass && go;
        r.ps  = s.ps && pass && go;
        r.fl  = mflags[d][idx];
        r.cnt = 16'(mcnt[d]);
        if (d == 0) qa.push_back(r);
        else qb.push_back(r);
        if (s.rst) begin
            for (int k = 0; k < 4; k++) mflags[d][k] = 4'b0;
            mcnt[d] = 0;
        end else if (s.en) begin
            if (pass) begin
                if (s.fw[1]) mflags[d][idx][3:2] = s.alu[3:2];
                if (s.fw[0]) mflags[d][idx][1:0] = s.alu[1:0];
            end else if (s.op != 2'b11 && mcnt[d] < cmax) begin
                mcnt[d] = mcnt[d] + 1;
            end
        end
    endtask

    task automatic apply(stim_t sa, stim_t sb);
        @(posedge clk);
        #1;
        {a_rst, a_en, a_op, a_alu, a_fw, a_rwi, a_mwi, a_psi} =
            {sa.rst, sa.en, sa.op, sa.alu, sa.fw, sa.rw, sa.mw, sa.ps};
        a_cond = sa.cond[2:0];
        a_ctx  = sa.ctx[0];
        {b_rst, b_en, b_op, b_cond, b_ctx, b_alu, b_fw, b_rwi, b_mwi, b_psi} =
            {sb.rst, sb.en, sb.op, sb.cond, sb.ctx, sb.alu, sb.fw, sb.rw, sb.mw, sb.ps};
        model(0, sa);
        model(1, sb);
    endtask

    task automatic chk(string nm, resp_t act, resp_t exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cycle %0d: got ce=%b rw=%b mw=%b ps=%b flags=%b cnt=%0d, expected ce=%b rw=%b mw=%b ps=%b flags=%b cnt=%0d",
                     nm, cyc, act.ce, act.rw, act.mw, act.ps, act.fl, act.cnt,
                     exp.ce, exp.rw, exp.mw, exp.ps, exp.fl, exp.cnt);
        end
    endtask

    // Monitor: every cycle both instances present a response; compare against the head of each queue.
    resp_t ea, eb, aa, ab;
    always @(negedge clk) begin
        cyc++;
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            aa = {a_ce, a_rw, a_mw, a_ps, a_flags, 16'(a_skip)};
            chk("asip", aa, ea);
        end
        if (qb.size() != 0) begin
            eb = qb.pop_front();
            ab = {b_ce, b_rw, b_mw, b_ps, b_flags, 16'(b_skip)};
            chk("arm", ab, eb);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            for (int k = 0; k < 4; k++) mflags[d][k] = 4'b0;
        end
        {a_rst, a_en, a_op, a_cond, a_ctx, a_alu, a_fw, a_rwi, a_mwi, a_psi} = '0;
        {b_rst, b_en, b_op, b_cond, b_ctx, b_alu, b_fw, b_rwi, b_mwi, b_psi} = '0;
        a_rst = 1'b1;
        b_rst = 1'b1;
        repeat (2) @(posedge clk);

        // ASIP instance: reset cycle, compare then branch, signed conditions, illegal op
        apply(mk(1, 1, 2, 0, 0, 4'hf, 3, 1, 1, 1), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 0, 4'b0100, 3, 1, 0, 0), idle);
        apply(mk(0, 1, 2, 1, 0, 0, 0, 0, 0, 1), idle);
        apply(mk(0, 1, 2, 6, 0, 0, 0, 0, 0, 1), idle);
        apply(mk(0, 1, 0, 0, 0, 4'b1000, 3, 0, 0, 0), idle);
        apply(mk(0, 1, 2, 2, 0, 0, 0, 1, 1, 1), idle);
        apply(mk(0, 1, 2, 5, 0, 0, 0, 1, 1, 1), idle);
        apply(mk(0, 1, 2, 4, 0, 0, 0, 1, 1, 1), idle);
        apply(mk(0, 1, 2, 7, 0, 0, 0, 1, 1, 1), idle);
        apply(mk(0, 1, 3, 0, 0, 4'hf, 3, 1, 1, 1), idle);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), idle);

        // Counter saturation with a stall in the middle, then mid-sequence reset
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), idle);
        for (int i = 0; i < 6; i++) begin
            apply(mk(0, (i != 2), 2, 7, 0, 0, 0, 0, 0, 1), idle);
        end
        apply(mk(0, 1, 2, 7, 0, 0, 0, 0, 0, 1), idle);
        apply(mk(1, 1, 2, 0, 0, 4'hf, 3, 1, 1, 1), idle);
        apply(mk(0, 1, 2, 0, 0, 0, 0, 1, 1, 1), idle);

        // ARM instance: per-context banks, partial write, squashed compare, aliased context
        apply(idle, mk(0, 1, 0, 14, 0, 4'b0100, 3, 0, 0, 0));
        apply(idle, mk(0, 1, 0, 14, 1, 4'b0010, 3, 0, 0, 0));
        apply(idle, mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
        apply(idle, mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 1));
        apply(idle, mk(0, 1, 2, 2, 1, 0, 0, 0, 0, 1));
        apply(idle, mk(0, 1, 0, 14, 0, 4'b1011, 1, 0, 0, 0));
        apply(idle, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(idle, mk(0, 1, 0, 0, 1, 4'hf, 3, 1, 0, 0));
        apply(idle, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        apply(idle, mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        apply(idle, mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        for (int i = 0; i < 600; i++) begin
            apply(rnd(), rnd());
        end

        @(negedge clk);
        #1;
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d/%0d responses left unchecked, expected 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
